// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM-stage requester and the data-memory responder.
// Requests use valid/ready: a transfer occurs on a rising edge where req_valid and req_ready are both 1; the response is a single-cycle resp_valid strobe with no backpressure.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: accepts one load/store, waits LATENCY cycles, then
// returns a one-cycle response with read data or an alignment/range error.
module dmem_responder #(
  parameter int DEPTH_WORDS = 32,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_responder_if.slave       bus,
  output logic [31:0]           mem1,
  output logic [31:0]           mem2,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);

  state_t      state;
  logic [2:0]  cnt;
  logic        lat_write;
  logic [6:0]  lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] mem [DEPTH_WORDS];

  logic [4:0]  idx;
  logic        bad_access;

  assign idx        = lat_addr[6:2];
  assign bad_access = (lat_addr[1:0] != 2'b00) || (32'(idx) >= DEPTH_WORDS);

  // Ready depends only on the state register, never on the request inputs.
  assign bus.req_ready = (state == S_IDLE);
  assign state_dbg     = state;
  assign mem1          = mem[0];
  assign mem2          = mem[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= 3'd0;
      lat_write      <= 1'b0;
      lat_addr       <= 7'd0;
      lat_wdata      <= 32'd0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'd0;
      bus.resp_err   <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= 32'd0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            lat_write <= bus.req_write;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            cnt       <= LAT_M1;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 3'd0) begin
            state          <= S_RESP;
            bus.resp_valid <= 1'b1;
            // The array is touched only on the edge that enters RESP.
            if (bad_access) begin
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= 32'd0;
            end else if (lat_write) begin
              mem[idx]       <= lat_wdata;
              bus.resp_err   <= 1'b0;
              bus.resp_rdata <= 32'd0;
            end else begin
              bus.resp_err   <= 1'b0;
              bus.resp_rdata <= mem[idx];
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_RESP: begin
          state          <= S_IDLE;
          bus.resp_valid <= 1'b0;
        end
        default: begin
          state          <= S_IDLE;
          bus.resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 7) sharing one request driver,
// table-driven transactions with a response scoreboard, plus held-request and reset corner cases.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic        tb_valid = 1'b0;
  logic        tb_write = 1'b0;
  logic [6:0]  tb_addr  = 7'd0;
  logic [31:0] tb_wdata = 32'd0;
  int          sel      = 0;

  dmem_responder_if if2 ();
  dmem_responder_if if1 ();
  dmem_responder_if if7 ();

  logic [31:0] m1_2, m2_2, m1_1, m2_1, m1_7, m2_7;
  logic [1:0]  st_2, st_1, st_7;

  assign if2.req_valid = tb_valid && (sel == 0);
  assign if1.req_valid = tb_valid && (sel == 1);
  assign if7.req_valid = tb_valid && (sel == 2);
  assign if2.req_write = tb_write;
  assign if1.req_write = tb_write;
  assign if7.req_write = tb_write;
  assign if2.req_addr  = tb_addr;
  assign if1.req_addr  = tb_addr;
  assign if7.req_addr  = tb_addr;
  assign if2.req_wdata = tb_wdata;
  assign if1.req_wdata = tb_wdata;
  assign if7.req_wdata = tb_wdata;

  dmem_responder #(.DEPTH_WORDS(32), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave), .mem1(m1_2), .mem2(m2_2), .state_dbg(st_2)
  );
  dmem_responder #(.DEPTH_WORDS(32), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave), .mem1(m1_1), .mem2(m2_1), .state_dbg(st_1)
  );
  dmem_responder #(.DEPTH_WORDS(32), .LATENCY(7)) dut7 (
    .clk(clk), .rst(rst), .bus(if7.slave), .mem1(m1_7), .mem2(m2_7), .state_dbg(st_7)
  );

  // Observation mux for the currently selected instance
  logic        s_ready, s_rvalid, s_err;
  logic [31:0] s_rdata, s_m1, s_m2;
  logic [1:0]  s_state;
  int          s_lat;

  always_comb begin
    s_ready = if2.req_ready; s_rvalid = if2.resp_valid; s_err = if2.resp_err;
    s_rdata = if2.resp_rdata; s_m1 = m1_2; s_m2 = m2_2; s_state = st_2; s_lat = 2;
    if (sel == 1) begin
      s_ready = if1.req_ready; s_rvalid = if1.resp_valid; s_err = if1.resp_err;
      s_rdata = if1.resp_rdata; s_m1 = m1_1; s_m2 = m2_1; s_state = st_1; s_lat = 1;
    end else if (sel == 2) begin
      s_ready = if7.req_ready; s_rvalid = if7.resp_valid; s_err = if7.resp_err;
      s_rdata = if7.resp_rdata; s_m1 = m1_7; s_m2 = m2_7; s_state = st_7; s_lat = 7;
    end
  end

  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_m1;
    logic [31:0] exp_m2;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t sel=%0d)", name, act, exp, $time, sel);
    end
  endtask

  // One full transaction: drive, check acceptance, measure latency, score the response.
  task automatic txn(input logic wr, input logic [6:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err,
                     input logic [31:0] exp_m1, input logic [31:0] exp_m2);
    logic [32:0] e;
    int   k;
    logic got;
    logic overlap;
    @(negedge clk);
    check("ready_before_req", {31'b0, s_ready}, 32'd1);
    tb_write = wr;
    tb_addr  = addr;
    tb_wdata = wdata;
    tb_valid = 1'b1;
    exp_q.push_back({exp_err, exp_rdata});
    @(posedge clk);
    #1;
    tb_valid = 1'b0;
    check("ready_in_wait", {31'b0, s_ready}, 32'd0);
    got = 1'b0;
    overlap = 1'b0;
    k = 0;
    while (!got && k < 20) begin
      @(posedge clk);
      #1;
      k++;
      if (s_ready && s_rvalid) overlap = 1'b1;
      if (s_rvalid) got = 1'b1;
    end
    check("ready_valid_overlap", {31'b0, overlap}, 32'd0);
    if (!got) begin
      check("resp_timeout", 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      check("resp_latency", 32'(k), 32'(s_lat));
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("resp_rdata", s_rdata, e[31:0]);
        check("resp_err", {31'b0, s_err}, {31'b0, e[32]});
      end
      check("mem1", s_m1, exp_m1);
      check("mem2", s_m2, exp_m2);
      @(posedge clk);
      #1;
      check("resp_valid_one_cycle", {31'b0, s_rvalid}, 32'd0);
      check("ready_after_resp", {31'b0, s_ready}, 32'd1);
      check("rdata_hold", s_rdata, e[31:0]);
    end
  endtask

  initial begin
    int   nresp;
    int   last;
    logic ovl;
    logic seen;
    logic [31:0] rnd;

    vecs[0]  = '{1'b0, 7'h08, 32'h0,        32'h0,        1'b0, 32'h0,        32'h0};
    vecs[1]  = '{1'b1, 7'h04, 32'hDEADBEEF, 32'h0,        1'b0, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b0, 7'h04, 32'h0,        32'hDEADBEEF, 1'b0, 32'h0,        32'hDEADBEEF};
    vecs[3]  = '{1'b1, 7'h06, 32'h12345678, 32'h0,        1'b1, 32'h0,        32'hDEADBEEF};
    vecs[4]  = '{1'b0, 7'h03, 32'h0,        32'h0,        1'b1, 32'h0,        32'hDEADBEEF};
    vecs[5]  = '{1'b1, 7'h00, 32'h11223344, 32'h0,        1'b0, 32'h11223344, 32'hDEADBEEF};
    vecs[6]  = '{1'b0, 7'h00, 32'h0,        32'h11223344, 1'b0, 32'h11223344, 32'hDEADBEEF};
    vecs[7]  = '{1'b1, 7'h7C, 32'hCAFEF00D, 32'h0,        1'b0, 32'h11223344, 32'hDEADBEEF};
    vecs[8]  = '{1'b0, 7'h7C, 32'h0,        32'hCAFEF00D, 1'b0, 32'h11223344, 32'hDEADBEEF};
    vecs[9]  = '{1'b1, 7'h08, 32'h55AA55AA, 32'h0,        1'b0, 32'h11223344, 32'hDEADBEEF};
    vecs[10] = '{1'b0, 7'h08, 32'h0,        32'h55AA55AA, 1'b0, 32'h11223344, 32'hDEADBEEF};

    // Reset state of every instance
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("reset_mem1", s_m1, 32'd0);
      check("reset_mem2", s_m2, 32'd0);
      check("reset_ready", {31'b0, s_ready}, 32'd1);
      check("reset_resp_valid", {31'b0, s_rvalid}, 32'd0);
      check("reset_state", {30'b0, s_state}, 32'd0);
    end

    sel = 0;
    for (int i = 0; i < 11; i++) begin
      txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err,
          vecs[i].exp_m1, vecs[i].exp_m2);
    end

    // Held request: load 0x00 with req_valid never dropped
    @(negedge clk);
    tb_write = 1'b0;
    tb_addr  = 7'h00;
    tb_valid = 1'b1;
    nresp = 0;
    last  = -1;
    ovl   = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      if (s_ready && s_rvalid) ovl = 1'b1;
      if (s_rvalid) begin
        nresp++;
        if (last >= 0) check("held_period", 32'(c - last), 32'd4);
        last = c;
        check("held_rdata", s_rdata, 32'h11223344);
      end
    end
    tb_valid = 1'b0;
    check("held_resp_count", 32'(nresp), 32'd4);
    check("held_overlap", {31'b0, ovl}, 32'd0);

    // Reset during WAIT of a store to word 0
    repeat (2) @(posedge clk);
    @(negedge clk);
    tb_write = 1'b1;
    tb_addr  = 7'h00;
    tb_wdata = 32'hA5A5A5A5;
    tb_valid = 1'b1;
    @(posedge clk);
    #1;
    tb_valid = 1'b0;
    check("midrst_in_wait", {30'b0, s_state}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_async_ready", {31'b0, s_ready}, 32'd1);
    check("midrst_async_mem1", s_m1, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (s_rvalid) seen = 1'b1;
    end
    check("midrst_no_resp", {31'b0, seen}, 32'd0);
    check("midrst_mem1", s_m1, 32'd0);
    check("midrst_mem2", s_m2, 32'd0);
    check("midrst_ready", {31'b0, s_ready}, 32'd1);

    // LATENCY=1 instance
    sel = 1;
    txn(1'b1, 7'h7C, 32'h0BADC0DE, 32'h0,        1'b0, 32'h0, 32'h0);
    txn(1'b0, 7'h7C, 32'h0,        32'h0BADC0DE, 1'b0, 32'h0, 32'h0);
    txn(1'b0, 7'h01, 32'h0,        32'h0,        1'b1, 32'h0, 32'h0);

    // LATENCY=7 instance
    sel = 2;
    rnd = $urandom_range(32'h7FFF_FFFF, 32'h1);
    txn(1'b1, 7'h7C, 32'h13579BDF, 32'h0,        1'b0, 32'h0, 32'h0);
    txn(1'b0, 7'h7C, 32'h0,        32'h13579BDF, 1'b0, 32'h0, 32'h0);
    txn(1'b1, 7'h04, rnd,          32'h0,        1'b0, 32'h0, rnd);
    txn(1'b0, 7'h04, 32'h0,        rnd,          1'b0, 32'h0, rnd);
    txn(1'b0, 7'h7E, 32'h0,        32'h0,        1'b1, 32'h0, rnd);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0t required=<500000", $time);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder: the target end of the MEM-stage data-memory request interface. It accepts one load or store at a time through a valid/ready handshake, services it after a programmable wait, and returns a single-cycle response carrying read data or an alignment error. The pipeline's hazard logic stalls on `req_ready`/`resp_valid`. Words 0 and 1 are exported as `mem1`/`mem2` for debug, matching the core's top-level observation ports.

## Interface
- `DEPTH_WORDS`, default 32: number of 32-bit words. The index is `req_addr[6:2]`, so 32 covers the full 7-bit byte address space.
- `LATENCY`, default 2: cycles from acceptance to response. Legal range 1..7.

Ports:
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `req_valid` input, 1: request present.
- `req_write` input, 1: 1 = store, 0 = load.
- `req_addr` input, 7: byte address; word-aligned only.
- `req_wdata` input, 32: store data.
- `req_ready` output, 1: responder can accept a request.
- `resp_valid` output, 1: one-cycle response strobe.
- `resp_rdata` output, 32: load data. 0 for stores and for errors.
- `resp_err` output, 1: misaligned access. Qualified by `resp_valid`.
- `mem1` output, 32: word 0 (byte address 0). Combinational from the array.
- `mem2` output, 32: word 1 (byte address 4). Combinational from the array.

## Operation
- FSM states: IDLE, WAIT, RESP. Register `cnt` is 3 bits.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid` at a rising edge: latch write, addr and wdata; load `cnt`=LATENCY-1; go to WAIT.
  - Inputs are ignored when `req_valid`=0.
- **WAIT**
  - `req_ready`=0.
  - If `cnt`==0, go to RESP at the next edge; otherwise decrement `cnt`.
  - Request inputs are ignored; a held `req_valid` is not re-accepted.
- **Edge entering RESP**
  - If latched `addr[1:0]`≠0: no array access, `resp_err`←1, `resp_rdata`←0.
  - Else if store: array[addr[6:2]]←wdata, `resp_rdata`←0, `resp_err`←0.
  - Else (load): `resp_rdata`←array[addr[6:2]], `resp_err`←0.
- **RESP**
  - `resp_valid`=1 for exactly this one cycle; `req_ready`=0.
  - Next edge: go to IDLE and clear `resp_valid`.
  - `resp_rdata`/`resp_err` hold their values until the next response or reset.
- No response backpressure. The requester must sample during the RESP cycle.
- Throughput: one request per LATENCY+2 cycles.
- **Reset (`rst`=1, asynchronous)**
  - State←IDLE, `cnt`←0, `resp_valid`←0, `resp_rdata`←0, `resp_err`←0.
  - All array words←0; `mem1`=`mem2`=0.
  - `req_ready`=1 once `rst` deasserts.
- **Reset mid-operation:** the pending request is discarded. A store in WAIT is never committed, and no response is issued.
- Out-of-range indices cannot occur when DEPTH_WORDS=32. For smaller depths, index ≥ DEPTH_WORDS is reported as `resp_err`=1 with no access.

## Timing
- Request accepted at edge N means:
  - WAIT during cycles N..N+LATENCY-1.
  - RESP entered at edge N+LATENCY; `resp_valid` high for that one cycle.
  - IDLE (`req_ready`=1) from edge N+LATENCY+1.
- A store becomes visible on `mem1`/`mem2` and to later loads from edge N+LATENCY.
- `req_ready` and `resp_valid` are never both 1.
- `req_ready` is a decode of the state register only. It has no combinational path from any input.
- All outputs except `mem1`/`mem2` are registered.

## Test plan
- **Reset, then load:** after reset, check `mem1`=`mem2`=0 and `req_ready`=1. Load addr 0x08 → `resp_valid` one cycle at edge N+2 (LATENCY=2), `resp_rdata`=0, `resp_err`=0.
- **Store then load:** store 0xDEADBEEF to addr 0x04 → `mem2`=0xDEADBEEF from edge N+2. A following load of 0x04 returns 0xDEADBEEF. `resp_rdata` is 0 on the store response.
- **Misaligned store:** store 0x12345678 to addr 0x06 → `resp_err`=1, `resp_rdata`=0, no word changes (`mem2` unchanged).
- **Held request:** hold `req_valid`=1 continuously with a load of 0x00 → exactly one accept per 4 cycles (LATENCY=2), `resp_valid` every 4th cycle, never overlapping `req_ready`.
- **Reset mid-operation:** store 0xA5A5A5A5 to 0x00, assert `rst` during WAIT → no `resp_valid`, `mem1`=0, `req_ready`=1 after release.
- **LATENCY=1 and LATENCY=7:** store then load at addr 0x7C → responses at edges N+1 and N+7 respectively, with correct data.
